ddc_ring_reader: RTL and testbench



---
 rtl/ddc_ring_reader.sv | 199 +++++++++++++++++++
 tb/tb_ddc_ring_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_ring_reader.sv
// DDC baseband ring reader: follows the writer pointer of the ring RAM, reads
// fixed-length packets of {I,Q} words and streams them on an AXI4-Stream master
// with full backpressure. Writer-laps-reader overruns are counted and the read
// pointer is resynchronised to the writer.
module ddc_ring_reader #(
    parameter int U_DLY      = 1,
    parameter int MAX_ADDR   = 11520,
    parameter int PKT_LEN    = 256,
    parameter int RD_LAT     = 2,
    parameter int OVF_MARGIN = 64
) (
    input  logic        lbs_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [13:0] ddc_conv_waddr,
    output logic [13:0] lbs_addr,
    input  logic [31:0] ddc_conv_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] ovf_cnt,
    output logic        ovf_pulse
);

    localparam logic [13:0] LAST_ADDR = 14'(MAX_ADDR);
    localparam logic [14:0] RING_SIZE = 15'(MAX_ADDR + 1);
    localparam logic [14:0] OVF_LIMIT = 15'(MAX_ADDR + 1 - OVF_MARGIN);
    localparam logic [14:0] PKT_FILL  = 15'(PKT_LEN);
    localparam logic [12:0] PKT_WORDS = 13'(PKT_LEN);
    localparam logic [3:0]  CREDITS   = 4'd4;

    // U_DLY is accepted for compatibility with delayed-assignment simulation models;
    // this RTL applies no assignment delay.
    if (PKT_LEN < 2 || PKT_LEN > 4096 || RD_LAT < 1 || RD_LAT > 3 || U_DLY < 0) begin : g_bad_params
        $error("ddc_ring_reader: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] rd_ptr_q, rd_ptr_d;
    logic [13:0] lbs_addr_q, lbs_addr_d;
    logic [12:0] issued_q, issued_d;
    // Stage 0 lines up with lbs_addr; stage RD_LAT lines up with ddc_conv_data.
    logic [RD_LAT:0] vld_q, vld_d;
    logic [RD_LAT:0] lst_q, lst_d;
    logic [31:0] fifo_data_q [4];
    logic [31:0] fifo_data_d [4];
    logic [3:0]  fifo_last_q, fifo_last_d;
    logic [1:0]  fifo_wr_q, fifo_wr_d;
    logic [1:0]  fifo_rd_q, fifo_rd_d;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        ovf_pulse_q, ovf_pulse_d;

    logic [14:0] fill;
    logic [3:0]  in_flight;
    logic [3:0]  occupancy;
    logic        head_vld;
    logic        push;
    logic        pop;
    logic        issue;

    // Ring fill level between the reader and the writer, modulo the ring size.
    always_comb begin
        if (ddc_conv_waddr >= rd_ptr_q) begin
            fill = {1'b0, ddc_conv_waddr} - {1'b0, rd_ptr_q};
        end else begin
            fill = {1'b0, ddc_conv_waddr} + RING_SIZE - {1'b0, rd_ptr_q};
        end
    end

    // Number of reads issued whose data has not yet landed in the output FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            in_flight = in_flight + {3'b000, vld_q[i]};
        end
    end

    assign head_vld = (fifo_cnt_q != 3'd0);
    assign pop      = head_vld & m_axis_tready;
    assign push     = vld_q[RD_LAT];
    // A word leaving the FIFO this cycle frees its slot in time for a read issued
    // now, which keeps the stream at one word per cycle under full ready.
    assign occupancy = {1'b0, fifo_cnt_q} + in_flight - {3'b000, pop};

    // Next-state, read issue, overrun handling and output FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        lbs_addr_d  = lbs_addr_q;
        issued_d    = issued_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_pulse_d = 1'b0;
        issue       = 1'b0;
        vld_d       = {vld_q[RD_LAT-1:0], 1'b0};
        lst_d       = {lst_q[RD_LAT-1:0], 1'b0};
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    rd_ptr_d = ddc_conv_waddr;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (fill > OVF_LIMIT) begin
                    ovf_pulse_d = 1'b1;
                    if (ovf_cnt_q != 16'hFFFF) begin
                        ovf_cnt_d = ovf_cnt_q + 16'd1;
                    end
                    rd_ptr_d = ddc_conv_waddr;
                end else if (fill >= PKT_FILL) begin
                    issued_d = '0;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                issue = (issued_q < PKT_WORDS) && (occupancy < CREDITS);
                if (issue) begin
                    lbs_addr_d = rd_ptr_q;
                    rd_ptr_d   = (rd_ptr_q == LAST_ADDR) ? 14'd0 : rd_ptr_q + 14'd1;
                    issued_d   = issued_q + 13'd1;
                    vld_d[0]   = 1'b1;
                    lst_d[0]   = (issued_q == PKT_WORDS - 13'd1);
                end
                if (pop && fifo_last_q[fifo_rd_q]) begin
                    state_d = enable ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            fifo_data_d[fifo_wr_q] = ddc_conv_data;
            fifo_last_d[fifo_wr_q] = lst_q[RD_LAT];
            fifo_wr_d              = fifo_wr_q + 2'd1;
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + 2'd1;
        end
        fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    end

    // State, pointer, tag pipe and FIFO registers with synchronous active-low reset.
    always_ff @(posedge lbs_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            lbs_addr_q  <= '0;
            issued_q    <= '0;
            vld_q       <= '0;
            lst_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
            ovf_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            lbs_addr_q  <= lbs_addr_d;
            issued_q    <= issued_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_pulse_q <= ovf_pulse_d;
        end
    end

    assign lbs_addr      = lbs_addr_q;
    assign m_axis_tvalid = head_vld;
    assign m_axis_tdata  = fifo_data_q[fifo_rd_q];
    assign m_axis_tlast  = head_vld & fifo_last_q[fifo_rd_q];
    assign ovf_cnt       = ovf_cnt_q;
    assign ovf_pulse     = ovf_pulse_q;

endmodule

// File: tb/tb_ddc_ring_reader.sv
// Bench for ddc_ring_reader: RAM model with RD_LAT read latency, a scoreboard
// queue filled when a packet is triggered and drained by the stream monitor.
module tb_ddc_ring_reader;

    localparam int MAX_ADDR   = 11520;
    localparam int PKT_LEN    = 256;
    localparam int RD_LAT     = 2;
    localparam int OVF_MARGIN = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [13:0] waddr;
    logic [13:0] lbs_addr;
    logic [31:0] rdata;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic [15:0] ovf_cnt;
    logic        ovf_pulse;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          first_hs = 0;
    int          last_hs = 0;
    logic [31:0] ram_d [RD_LAT];

    always #5 clk = ~clk;

    ddc_ring_reader #(
        .U_DLY     (1),
        .MAX_ADDR  (MAX_ADDR),
        .PKT_LEN   (PKT_LEN),
        .RD_LAT    (RD_LAT),
        .OVF_MARGIN(OVF_MARGIN)
    ) dut (
        .lbs_clk       (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .ddc_conv_waddr(waddr),
        .lbs_addr      (lbs_addr),
        .ddc_conv_data (rdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .ovf_cnt       (ovf_cnt),
        .ovf_pulse     (ovf_pulse)
    );

    function automatic logic [31:0] ram_word(input logic [13:0] a);
        return {(16'(a) ^ 16'hA5A5), (16'(a) * 16'd3 + 16'd7)};
    endfunction

    // RAM read port: data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        ram_d[0] <= ram_word(lbs_addr);
        for (int k = 1; k < RD_LAT; k++) ram_d[k] <= ram_d[k-1];
    end
    assign rdata = ram_d[RD_LAT-1];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_pkt(input int start);
        exp_t e;
        for (int i = 0; i < PKT_LEN; i++) begin
            e.data = ram_word(14'((start + i) % (MAX_ADDR + 1)));
            e.last = (i == PKT_LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d words outstanding after %0d cycles, expected 0", tag, exp_q.size(), bound);
        end
    endtask

    task automatic wait_words(input int target, input int bound);
        int n = 0;
        while (hs_count < target && n < bound) begin
            cyc();
            n++;
        end
    endtask

    // Stream monitor: compares every handshake against the scoreboard and checks
    // that a stalled word holds its data and last flag.
    task automatic monitor();
        exp_t        e;
        logic        stall_prev = 1'b0;
        logic [31:0] stall_data = '0;
        logic        stall_last = 1'b0;
        int          ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n === 1'b1) begin
                if (stall_prev) begin
                    checks++;
                    assert (tvalid === 1'b1) else begin
                        errors++;
                        $error("FAIL hold_tvalid: observed %b expected 1", tvalid);
                    end
                    checks++;
                    assert (tdata === stall_data) else begin
                        errors++;
                        $error("FAIL hold_tdata: observed %h expected %h", tdata, stall_data);
                    end
                    checks++;
                    assert (tlast === stall_last) else begin
                        errors++;
                        $error("FAIL hold_tlast: observed %b expected %b", tlast, stall_last);
                    end
                end
                if (tvalid === 1'b1 && tready === 1'b1) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_word: observed tdata %h expected no output", tdata);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        assert (tdata === e.data) else begin
                            errors++;
                            $error("FAIL word_data: observed %h expected %h", tdata, e.data);
                        end
                        checks++;
                        assert (tlast === e.last) else begin
                            errors++;
                            $error("FAIL word_last: observed %b expected %b", tlast, e.last);
                        end
                    end
                    if (hs_count == 0) first_hs = ncyc;
                    last_hs = ncyc;
                    hs_count++;
                end
                stall_prev = (tvalid === 1'b1) && (tready !== 1'b1);
                stall_data = tdata;
                stall_last = tlast;
            end else begin
                stall_prev = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b0;
        waddr  = '0;
        tready = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_lbs_addr", lbs_addr, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_ovf_pulse", ovf_pulse, 0);
        cyc();
        rst_n = 1'b1;

        // Basic packet from address 100
        waddr  = 14'd100;
        enable = 1'b1;
        repeat (3) cyc();
        tready = 1'b1;
        @(negedge clk);
        chk("wait_no_output", tvalid, 0);
        cyc();
        push_pkt(100);
        hs_count = 0;
        waddr = 14'd356;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (tvalid === 1'b1) break;
        end
        chk("first_word_latency", n, RD_LAT + 3);
        wait_drain("pkt_basic", 400);
        chk("pkt_basic_count", hs_count, PKT_LEN);
        chk("pkt_basic_back_to_back", last_hs - first_hs, PKT_LEN - 1);

        // Packet wrapping through MAX_ADDR -> 0
        enable = 1'b0;
        repeat (2) cyc();
        waddr = 14'd11400;
        cyc();
        enable = 1'b1;
        repeat (3) cyc();
        push_pkt(11400);
        waddr = 14'd135;
        wait_drain("pkt_wrap", 400);

        // Backpressure: alternating ready with two long stalls
        push_pkt(135);
        waddr = 14'd391;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            tready = (i % 2 == 0) && !(i >= 40 && i < 60) && !(i >= 300 && i < 320);
            cyc();
        end
        wait_drain("pkt_backpressure", 10);
        tready = 1'b1;

        // enable dropped at word 50: packet completes, then no further reads
        push_pkt(391);
        hs_count = 0;
        waddr = 14'd647;
        wait_words(50, 200);
        enable = 1'b0;
        wait_drain("pkt_enable_drop", 400);
        chk("pkt_enable_drop_count", hs_count, PKT_LEN);
        waddr = 14'd1000;
        repeat (20) cyc();
        @(negedge clk);
        chk("idle_lbs_addr", lbs_addr, 646);
        chk("idle_tvalid", tvalid, 0);

        // Overrun in WAIT
        cyc();
        waddr = 14'd0;
        cyc();
        enable = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("pre_ovf_pulse", ovf_pulse, 0);
        cyc();
        waddr = 14'd11460;
        cyc();
        @(negedge clk);
        chk("ovf_pulse_high", ovf_pulse, 1);
        chk("ovf_cnt_one", ovf_cnt, 1);
        cyc();
        @(negedge clk);
        chk("ovf_pulse_one_cycle", ovf_pulse, 0);
        chk("ovf_cnt_hold", ovf_cnt, 1);
        repeat (10) cyc();
        @(negedge clk);
        chk("ovf_no_packet", tvalid, 0);
        cyc();
        push_pkt(11460);
        waddr = 14'd195;
        wait_drain("pkt_after_ovf", 400);

        // Reset for one cycle in the middle of a packet
        push_pkt(195);
        hs_count = 0;
        waddr = 14'd451;
        wait_words(30, 200);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_tlast", tlast, 0);
        chk("midrst_lbs_addr", lbs_addr, 0);
        chk("midrst_ovf_cnt", ovf_cnt, 0);
        exp_q.delete();
        repeat (5) cyc();
        @(negedge clk);
        chk("post_rst_idle", tvalid, 0);
        cyc();
        push_pkt(451);
        waddr = 14'd707;
        wait_drain("pkt_after_rst", 400);

        repeat (5) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
